stack_alu: RTL
==============

Name: stack_alu

Overview:
- Clocked, parametrised successor to the stack unit: LIFO operand stack with an integrated ALU (ADD, SUB, MUL, DUP, SWAP) behind a valid/ready command interface.
- Generalised over operand WIDTH and stack DEPTH.
- Adds stack-error reporting, signed overflow detection and an iterative multiplier.
- Sits between the command sequencer and the result bus of the stack-based ALU datapath.

Parameters:
- WIDTH, 8: operand/result width in bits (two's complement).
- DEPTH, 16: stack entries, at least 2.
- PTR_W, $clog2(DEPTH+1): width of index.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  command present.
- in_ready  out  1  command accepted when in_valid && in_ready.
- opcode  in  3  000 NOP, 001 SUB, 010 DUP, 011 SWAP, 100 ADD, 101 MUL, 110 PUSH, 111 POP.
- in  in  WIDTH  PUSH operand.
- out_valid  out  1  one-cycle pulse; out, overflow and err are valid.
- out  out  WIDTH  command result.
- overflow  out  1  signed arithmetic overflow of this result.
- err  out  1  stack error; command had no effect.
- index  out  PTR_W  current number of stack entries.

Behaviour:
- Reset values: out=0, out_valid=0, overflow=0, err=0, index=0, FSM=IDLE. Stack contents are don't-care.
- in_ready=1 in IDLE, including the first cycle after reset release.
- FSM states:
  - IDLE: single-cycle ops execute here.
  - MULT: iterative multiply in progress; in_ready=0. Enter on an accepted MUL that passes its depth check; return to IDLE after WIDTH cycles.
- Single-cycle ops: stack and index update at the accept edge; out_valid pulses the following cycle.
- Operand naming: a = top, b = next. Binary ops pop a and b, push the result; index -= 1.
  - PUSH: push in; out=in; index += 1.
  - POP: out=a; index -= 1.
  - DUP: push a; out=a; index += 1.
  - SWAP: exchange a and b; out=b (the new top); index unchanged.
  - ADD: result b+a.
  - SUB: result b-a.
  - MUL: result b*a.
  - NOP: accepted; no out_valid; no state change.
- Width rules:
  - Results are stored and output as the low WIDTH bits.
  - ADD/SUB: overflow=1 iff the true signed result is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - MUL: full 2*WIDTH signed product; same overflow range check.
  - overflow=0 for non-arithmetic ops.
- MUL timing:
  - Operands are captured and popped at accept.
  - WIDTH iteration cycles, then the result is pushed.
  - out_valid rises exactly WIDTH+1 cycles after the accept edge.
  - in_ready returns to 1 in the same cycle as out_valid.
- Stack errors: err=1, out_valid pulses, out holds its previous value, overflow=0, stack and index unchanged. Triggers:
  - PUSH or DUP with index==DEPTH.
  - POP or DUP with index==0.
  - SWAP, ADD, SUB or MUL with index<2. Failed MUL does not enter MULT.
- Full/empty boundaries: PUSH at index DEPTH-1 succeeds (index=DEPTH). Binary op at exactly index==2 succeeds (index=1).
- Reset during MULT: aborts immediately; index=0, no out_valid; next command accepted after release.
- Sequencing: commands are processed strictly in order; no result is ever dropped or duplicated.

Decomposition:
- stack_alu_pkg: opcode localparams (OP_NOP..OP_POP), FSM state enum, and an overflow-check function.
- One sub-module, stack_seq_mult:
  - Iterative WIDTH-cycle signed shift-add multiplier.
  - Ports: start, a, b in; done, product[2*WIDTH-1:0] out.
  - Reset via rst_n.

Test Plan:
1. PUSH 1, 2, 3 -> out 1, 2, 3 with index 1, 2, 3; then ADD -> out=5, index=2, overflow=0.
2. PUSH 20, PUSH 10, SUB -> out=10. PUSH 100, PUSH 100, ADD -> out=8'hC8, overflow=1.
3. PUSH 6, PUSH 7, MUL -> in_ready low 8 cycles; out_valid at accept+9; out=42, overflow=0. PUSH 12, PUSH 11, MUL -> out=8'h84, overflow=1. PUSH -3, PUSH 5, MUL -> out=8'hF1, overflow=0.
4. 16 PUSHes -> index=16; 17th PUSH -> err=1, index=16, top unchanged; drain with POPs; POP on empty -> err=1, index=0.
5. PUSH 3, PUSH 9, SWAP -> out=3; POP -> out=3, index=1; DUP -> out=9, index=2; ADD with index=1 after one POP -> err=1.
6. rst_n low for 2 cycles mid-MUL -> index=0, no out_valid; in_ready=1 after release; next PUSH 4 -> out=4, index=1.

Source files
------------

// File: rtl/stack_alu_pkg.sv
// Shared opcodes, FSM states and overflow helper
// for the stack ALU datapath.
package stack_alu_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_DUP  = 3'b010;
  localparam logic [2:0] OP_SWAP = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  typedef enum logic {
    ST_IDLE,
    ST_MULT
  } state_t;

  // True when a sign-extended result does not fit in w signed bits.
  function automatic logic ovf_chk(
    input logic signed [63:0] v,
    input int unsigned        w
  );
    logic signed [63:0] lim;
    lim = 64'sd1 <<< (w - 1);
    return (v >= lim) || (v < -lim);
  endfunction

endpackage

// File: rtl/stack_seq_mult.sv
// Iterative signed shift-add multiplier.
// One partial product per cycle; the sign bit's is subtracted.
module stack_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic                 r_busy;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplr;

  logic                 w_last;
  logic [2*WIDTH-1:0]   w_pp;
  logic [2*WIDTH-1:0]   w_nxt;

  assign w_last  = (r_cnt == CW'(WIDTH - 1));
  assign w_pp    = r_mplr[0] ? r_mcand : '0;
  assign w_nxt   = w_last ? (r_acc - w_pp) : (r_acc + w_pp);
  // Product is presented combinationally on the final step.
  assign done    = r_busy && w_last;
  assign product = w_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
    end else if (start) begin
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mcand <= {{WIDTH{a[WIDTH-1]}}, a};
      r_mplr  <= b;
    end else if (r_busy) begin
      r_acc   <= w_nxt;
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/stack_alu.sv
// LIFO operand stack with integrated ALU behind a
// valid/ready command port; MUL runs on an iterative multiplier.
module stack_alu
  import stack_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             err,
  output logic [PTR_W-1:0] index
);

  localparam int AW = $clog2(DEPTH);

  state_t             r_state;
  logic [PTR_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_stk [DEPTH];

  logic               w_acc;
  logic               w_err;
  logic               w_full;
  logic               w_empty;
  logic               w_lt2;
  logic               w_mul_go;
  logic               w_done;
  logic [AW-1:0]      w_ia;
  logic [AW-1:0]      w_ib;
  logic [AW-1:0]      w_ip;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic signed [63:0] w_sum;
  logic signed [63:0] w_dif;
  logic signed [63:0] w_p64;
  logic [2*WIDTH-1:0] w_prod;

  assign in_ready = (r_state == ST_IDLE);
  assign index    = r_idx;
  assign w_acc    = in_valid && in_ready;

  assign w_full  = (r_idx == PTR_W'(DEPTH));
  assign w_empty = (r_idx == '0);
  assign w_lt2   = (r_idx < PTR_W'(2));

  assign w_ia = AW'(r_idx - PTR_W'(1));
  assign w_ib = AW'(r_idx - PTR_W'(2));
  assign w_ip = AW'(r_idx);
  assign w_a  = r_stk[w_ia];
  assign w_b  = r_stk[w_ib];

  assign w_sum = 64'($signed(w_b)) + 64'($signed(w_a));
  assign w_dif = 64'($signed(w_b)) - 64'($signed(w_a));
  assign w_p64 = 64'($signed(w_prod));

  always_comb begin
    w_err = 1'b0;
    unique case (opcode)
      OP_PUSH: w_err = w_full;
      OP_DUP:  w_err = w_full || w_empty;
      OP_POP:  w_err = w_empty;
      OP_SWAP,
      OP_ADD,
      OP_SUB,
      OP_MUL:  w_err = w_lt2;
      default: w_err = 1'b0;
    endcase
  end

  assign w_mul_go = w_acc && (opcode == OP_MUL) && !w_err;

  stack_seq_mult #(
    .WIDTH(WIDTH)
  ) u_mult (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (w_mul_go),
    .a      (w_a),
    .b      (w_b),
    .done   (w_done),
    .product(w_prod)
  );

  // Stack contents need no reset; index alone defines validity.
  always_ff @(posedge clk) begin
    if (r_state == ST_MULT && w_done) begin
      r_stk[w_ip] <= w_prod[WIDTH-1:0];
    end else if (w_acc && !w_err) begin
      unique case (opcode)
        OP_PUSH: r_stk[w_ip] <= in;
        OP_DUP:  r_stk[w_ip] <= w_a;
        OP_SWAP: begin
          r_stk[w_ia] <= w_b;
          r_stk[w_ib] <= w_a;
        end
        OP_ADD:  r_stk[w_ib] <= w_sum[WIDTH-1:0];
        OP_SUB:  r_stk[w_ib] <= w_dif[WIDTH-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_acc && opcode != OP_NOP) begin
            err       <= w_err;
            overflow  <= 1'b0;
            out_valid <= !w_mul_go;
            if (!w_err) begin
              unique case (opcode)
                OP_PUSH: begin
                  out   <= in;
                  r_idx <= r_idx + PTR_W'(1);
                end
                OP_POP: begin
                  out   <= w_a;
                  r_idx <= r_idx - PTR_W'(1);
                end
                OP_DUP: begin
                  out   <= w_a;
                  r_idx <= r_idx + PTR_W'(1);
                end
                OP_SWAP: out <= w_b;
                OP_ADD: begin
                  out      <= w_sum[WIDTH-1:0];
                  overflow <= ovf_chk(w_sum, WIDTH);
                  r_idx    <= r_idx - PTR_W'(1);
                end
                OP_SUB: begin
                  out      <= w_dif[WIDTH-1:0];
                  overflow <= ovf_chk(w_dif, WIDTH);
                  r_idx    <= r_idx - PTR_W'(1);
                end
                OP_MUL: begin
                  r_state <= ST_MULT;
                  r_idx   <= r_idx - PTR_W'(2);
                end
                default: ;
              endcase
            end
          end
        end
        ST_MULT: begin
          if (w_done) begin
            r_state   <= ST_IDLE;
            out_valid <= 1'b1;
            err       <= 1'b0;
            out       <= w_prod[WIDTH-1:0];
            overflow  <= ovf_chk(w_p64, WIDTH);
            r_idx     <= r_idx + PTR_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
